// File: rtl/cplx_pkg.sv
// Shared constants for the complex fixed-point ALU: op codes, FSM encoding,
// field widths and sign-extension helpers.
package cplx_pkg;

    localparam int WORD  = 64;
    localparam int FIELD = 32;
    localparam int SUM_W = 66;

    typedef enum logic [2:0] {
        OP_ADD    = 3'b000,
        OP_SUB    = 3'b001,
        OP_MUL    = 3'b010,
        OP_CONJ   = 3'b011,
        OP_NEG    = 3'b100,
        OP_MAC    = 3'b101,
        OP_CLRACC = 3'b110,
        OP_NOP    = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EXEC = 3'd1,
        ST_MUL0 = 3'd2,
        ST_MUL1 = 3'd3,
        ST_MUL2 = 3'd4,
        ST_MUL3 = 3'd5,
        ST_WB   = 3'd6
    } state_e;

    function automatic logic signed [SUM_W-1:0] sext_field(input logic [FIELD-1:0] v);
        return {{(SUM_W-FIELD){v[FIELD-1]}}, v};
    endfunction

    function automatic logic signed [SUM_W-1:0] sext_prod(input logic [2*FIELD-1:0] v);
        return {{(SUM_W-2*FIELD){v[2*FIELD-1]}}, v};
    endfunction

endpackage

// File: rtl/cplx_sat.sv
// Reduces a wide signed field sum to 32 bits: clamps and flags overflow when
// CPLX_ALU_SAT_EN is defined, otherwise wraps modulo 2^32 with no flag.
module cplx_sat
    import cplx_pkg::*;
(
    input  logic [SUM_W-1:0] din,
    output logic [FIELD-1:0] dout,
    output logic             ovf
);

    // Bits above the 32-bit field only matter for range detection.
    logic unused_hi_s;
    assign unused_hi_s = ^din[SUM_W-1:FIELD];

`ifdef CPLX_ALU_SAT_EN
    logic in_range_s;
    assign in_range_s = (&din[SUM_W-1:FIELD-1]) | ~(|din[SUM_W-1:FIELD-1]);

    // Clamp toward the sign of the true result when it does not fit.
    always_comb begin
        dout = din[FIELD-1:0];
        ovf  = 1'b0;
        if (in_range_s) begin
            dout = din[FIELD-1:0];
            ovf  = 1'b0;
        end else begin
            dout = din[SUM_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            ovf  = 1'b1;
        end
    end
`else
    assign dout = din[FIELD-1:0];
    assign ovf  = 1'b0;
`endif

endmodule

// File: rtl/cplx_alu.sv
// Complex Q-format ALU with a shared 32x32 multiplier and register-bank write-back.
// Define CPLX_ALU_SAT_EN for per-field saturation; the default build wraps.
module cplx_alu
    import cplx_pkg::*;
#(
    parameter int FRAC_BITS = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [WORD-1:0] opA,
    input  logic [WORD-1:0] opB,
    input  logic [3:0]      dstreg,
    output logic            busy,
    output logic            done,
    output logic            regwen,
    output logic [3:0]      selwreg,
    output logic [1:0]      endwreg,
    output logic [WORD-1:0] inA,
    output logic            overflow
);

    state_e state_r, next_state_s;
    op_e    op_r;
    logic [WORD-1:0] opa_r, opb_r, acc_r, ina_r;
    logic [3:0] dst_r, selwreg_r;
    logic [1:0] endwreg_r;
    logic busy_r, done_r, regwen_r, overflow_r;
    logic signed [SUM_W-1:0] sum_re_r, sum_im_r;

    logic signed [FIELD-1:0]   mul_a_s, mul_b_s;
    logic signed [2*FIELD-1:0] prod_s;
    logic signed [SUM_W-1:0]   mul_re_s, mul_im_full_s, mul_im_s;
    logic signed [SUM_W-1:0]   sat_re_in_s, sat_im_in_s;
    logic [FIELD-1:0] sat_re_s, sat_im_s;
    logic ovf_re_s, ovf_im_s;
    logic finish_s;

    assign busy     = busy_r;
    assign done     = done_r;
    assign regwen   = regwen_r;
    assign selwreg  = selwreg_r;
    assign endwreg  = endwreg_r;
    assign inA      = ina_r;
    assign overflow = overflow_r;

    // Next-state logic.
    always_comb begin
        next_state_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = (op_e'(op) == OP_MUL || op_e'(op) == OP_MAC) ? ST_MUL0 : ST_EXEC;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_EXEC: next_state_s = ST_WB;
            ST_MUL0: next_state_s = ST_MUL1;
            ST_MUL1: next_state_s = ST_MUL2;
            ST_MUL2: next_state_s = ST_MUL3;
            ST_MUL3: next_state_s = ST_WB;
            ST_WB:   next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Shared multiplier operand select, one partial product per MUL state.
    always_comb begin
        mul_a_s = 32'sd0;
        mul_b_s = 32'sd0;
        case (state_r)
            ST_MUL0: begin mul_a_s = opa_r[63:32]; mul_b_s = opb_r[63:32]; end
            ST_MUL1: begin mul_a_s = opa_r[31:0];  mul_b_s = opb_r[31:0];  end
            ST_MUL2: begin mul_a_s = opa_r[63:32]; mul_b_s = opb_r[31:0];  end
            ST_MUL3: begin mul_a_s = opa_r[31:0];  mul_b_s = opb_r[63:32]; end
            default: begin mul_a_s = 32'sd0;       mul_b_s = 32'sd0;       end
        endcase
    end

    assign prod_s        = mul_a_s * mul_b_s;
    assign mul_re_s      = sum_re_r >>> FRAC_BITS;
    // The last partial product is folded in combinationally during MUL3.
    assign mul_im_full_s = sum_im_r + sext_prod(prod_s);
    assign mul_im_s      = mul_im_full_s >>> FRAC_BITS;
    assign finish_s      = (state_r == ST_EXEC) || (state_r == ST_MUL3);

    // Wide per-field result ahead of the 32-bit reduction.
    always_comb begin
        sat_re_in_s = '0;
        sat_im_in_s = '0;
        case (op_r)
            OP_ADD: begin
                sat_re_in_s = sext_field(opa_r[63:32]) + sext_field(opb_r[63:32]);
                sat_im_in_s = sext_field(opa_r[31:0])  + sext_field(opb_r[31:0]);
            end
            OP_SUB: begin
                sat_re_in_s = sext_field(opa_r[63:32]) - sext_field(opb_r[63:32]);
                sat_im_in_s = sext_field(opa_r[31:0])  - sext_field(opb_r[31:0]);
            end
            OP_CONJ: begin
                sat_re_in_s = sext_field(opa_r[63:32]);
                sat_im_in_s = -sext_field(opa_r[31:0]);
            end
            OP_NEG: begin
                sat_re_in_s = -sext_field(opa_r[63:32]);
                sat_im_in_s = -sext_field(opa_r[31:0]);
            end
            OP_MUL: begin
                sat_re_in_s = mul_re_s;
                sat_im_in_s = mul_im_s;
            end
            OP_MAC: begin
                sat_re_in_s = sext_field(acc_r[63:32]) + mul_re_s;
                sat_im_in_s = sext_field(acc_r[31:0])  + mul_im_s;
            end
            default: begin
                sat_re_in_s = '0;
                sat_im_in_s = '0;
            end
        endcase
    end

    cplx_sat u_sat_re (.din(sat_re_in_s), .dout(sat_re_s), .ovf(ovf_re_s));
    cplx_sat u_sat_im (.din(sat_im_in_s), .dout(sat_im_s), .ovf(ovf_im_s));

    // FSM state and write-back port registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            regwen_r   <= 1'b0;
            overflow_r <= 1'b0;
            endwreg_r  <= 2'b00;
            selwreg_r  <= 4'd0;
            ina_r      <= 64'd0;
        end else begin
            state_r    <= next_state_s;
            busy_r     <= (next_state_s != ST_IDLE);
            done_r     <= finish_s;
            regwen_r   <= finish_s && (op_r != OP_NOP);
            overflow_r <= finish_s && (ovf_re_s | ovf_im_s);
            endwreg_r  <= 2'b00;
            if (finish_s && (op_r != OP_NOP)) begin
                selwreg_r <= dst_r;
                ina_r     <= {sat_re_s, sat_im_s};
            end else begin
                selwreg_r <= selwreg_r;
                ina_r     <= ina_r;
            end
        end
    end

    // Operand capture, partial-sum accumulation and the MAC accumulator.
    always_ff @(posedge clock) begin
        if (reset) begin
            op_r     <= OP_NOP;
            opa_r    <= 64'd0;
            opb_r    <= 64'd0;
            dst_r    <= 4'd0;
            sum_re_r <= '0;
            sum_im_r <= '0;
            acc_r    <= 64'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        op_r     <= op_e'(op);
                        opa_r    <= opA;
                        opb_r    <= opB;
                        dst_r    <= dstreg;
                        sum_re_r <= '0;
                        sum_im_r <= '0;
                    end else begin
                        op_r <= op_r;
                    end
                end
                ST_EXEC: begin
                    if (op_r == OP_CLRACC) begin
                        acc_r <= 64'd0;
                    end else begin
                        acc_r <= acc_r;
                    end
                end
                ST_MUL0: sum_re_r <= sext_prod(prod_s);
                ST_MUL1: sum_re_r <= sum_re_r - sext_prod(prod_s);
                ST_MUL2: sum_im_r <= sext_prod(prod_s);
                ST_MUL3: begin
                    sum_im_r <= mul_im_full_s;
                    if (op_r == OP_MAC) begin
                        acc_r <= {sat_re_s, sat_im_s};
                    end else begin
                        acc_r <= acc_r;
                    end
                end
                default: op_r <= op_r;
            endcase
        end
    end

endmodule

// File: tb/tb_cplx_alu.sv
// Directed, table-driven bench for cplx_alu with hand-computed Q15.16 results,
// plus sequences for start-while-busy and reset mid-multiply.
module tb_cplx_alu;

`ifdef CPLX_ALU_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, MUL = 3'b010, CONJ = 3'b011;
    localparam logic [2:0] NEG = 3'b100, MAC = 3'b101, CLR = 3'b110, NOP = 3'b111;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b111;
    logic [63:0] opA = 64'd0, opB = 64'd0;
    logic [3:0]  dstreg = 4'd0;
    logic        busy, done, regwen, overflow;
    logic [3:0]  selwreg;
    logic [1:0]  endwreg;
    logic [63:0] inA;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  dst;
        logic [63:0] exp;
        logic        ovf;
        logic        wen;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    cplx_alu #(.FRAC_BITS(16)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .opA(opA), .opB(opB), .dstreg(dstreg),
        .busy(busy), .done(done), .regwen(regwen), .selwreg(selwreg),
        .endwreg(endwreg), .inA(inA), .overflow(overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add_vec(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                                    input logic [3:0] d, input logic [63:0] e, input logic f);
        vec_t v;
        v.op  = o;
        v.a   = a;
        v.b   = b;
        v.dst = d;
        v.exp = e;
        v.ovf = f;
        v.wen = (o != NOP);
        v.lat = (o == MUL || o == MAC) ? 5 : 2;
        vecs.push_back(v);
    endfunction

    // Returns one cycle after the sampling edge (cycle 1 of the operation).
    task automatic launch(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b, input logic [3:0] d);
        @(negedge clock);
        start = 1'b1; op = o; opA = a; opB = b; dstreg = d;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clock);
            #1;
            lat++;
        end
        if (done !== 1'b1) lat = -1;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int lat;
        launch(v.op, v.a, v.b, v.dst);
        chk({tag, " busy"}, 64'(busy), 64'(1));
        wait_done(lat);
        chk({tag, " latency"}, 64'(lat), 64'(v.lat));
        if (lat > 0) begin
            chk({tag, " regwen"}, 64'(regwen), 64'(v.wen));
            chk({tag, " overflow"}, 64'(overflow), 64'(v.ovf));
            chk({tag, " endwreg"}, 64'(endwreg), 64'(0));
            if (v.wen) begin
                chk({tag, " selwreg"}, 64'(selwreg), 64'(v.dst));
                chk({tag, " inA"}, inA, v.exp);
            end
            @(posedge clock);
            #1;
            chk({tag, " done pulse"}, 64'(done), 64'(0));
            chk({tag, " idle busy"}, 64'(busy), 64'(0));
        end
    endtask

    initial begin
        int dones;
        logic [63:0] got;
        vec_t v;

        add_vec(ADD,  64'h00010000_00020000, 64'h00030000_00040000, 4'd5, 64'h00040000_00060000, 1'b0);
        add_vec(SUB,  64'h00010000_00020000, 64'h00030000_00040000, 4'd3, 64'hFFFE0000_FFFE0000, 1'b0);
        add_vec(MUL,  64'h00010000_00020000, 64'h00030000_00040000, 4'd7, 64'hFFFB0000_000A0000, 1'b0);
        add_vec(CONJ, 64'h00010000_00020000, 64'd0,                 4'd2, 64'h00010000_FFFE0000, 1'b0);
        add_vec(NEG,  64'h00010000_00020000, 64'd0,                 4'd1, 64'hFFFF0000_FFFE0000, 1'b0);
        add_vec(NOP,  64'h12345678_9ABCDEF0, 64'd0,                 4'd9, 64'd0,                 1'b0);
        add_vec(ADD,  64'h7FFF0000_00000000, 64'h00020000_00000000, 4'd4,
                SAT ? 64'h7FFFFFFF_00000000 : 64'h80010000_00000000, SAT);
        add_vec(NEG,  64'h80000000_00000005, 64'd0,                 4'd6,
                SAT ? 64'h7FFFFFFF_FFFFFFFB : 64'h80000000_FFFFFFFB, SAT);
        add_vec(SUB,  64'h80000000_00000000, 64'h00000001_00000000, 4'd8,
                SAT ? 64'h80000000_00000000 : 64'h7FFFFFFF_00000000, SAT);
        add_vec(MUL,  64'h00008000_FFFF0000, 64'h00020000_00004000, 4'd10, 64'h00014000_FFFE2000, 1'b0);
        add_vec(MUL,  64'hFFFFFFFF_00000000, 64'h00008000_00000000, 4'd11, 64'hFFFFFFFF_00000000, 1'b0);
        add_vec(MUL,  64'h7FFF0000_00000000, 64'h00040000_00000000, 4'd12,
                SAT ? 64'h7FFFFFFF_00000000 : 64'hFFFC0000_00000000, SAT);
        add_vec(CLR,  64'h11111111_22222222, 64'h33333333_44444444, 4'd13, 64'd0, 1'b0);
        add_vec(MAC,  64'h00010000_00000000, 64'h00020000_00000000, 4'd14, 64'h00020000_00000000, 1'b0);
        add_vec(MAC,  64'h00010000_00000000, 64'h00020000_00000000, 4'd14, 64'h00040000_00000000, 1'b0);
        add_vec(MAC,  64'h7FFF0000_00000000, 64'h00010000_00000000, 4'd15,
                SAT ? 64'h7FFFFFFF_00000000 : 64'h80030000_00000000, SAT);

        repeat (3) @(posedge clock);
        #1;
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset done", 64'(done), 64'(0));
        chk("reset regwen", 64'(regwen), 64'(0));
        chk("reset overflow", 64'(overflow), 64'(0));
        chk("reset endwreg", 64'(endwreg), 64'(0));
        chk("reset selwreg", 64'(selwreg), 64'(0));
        chk("reset inA", inA, 64'd0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec($sformatf("v%0d", i), vecs[i]);
        end

        // start pulsed while in MUL1 must be dropped.
        launch(MUL, 64'h00010000_00020000, 64'h00030000_00040000, 4'd7);
        @(posedge clock);
        #1;
        start = 1'b1; op = ADD; opA = 64'h00010000_00010000; opB = 64'h00010000_00010000; dstreg = 4'd2;
        @(posedge clock);
        #1;
        start = 1'b0;
        dones = 0;
        got = 64'd0;
        for (int c = 0; c < 10; c++) begin
            if (done === 1'b1) begin
                dones++;
                got = inA;
            end
            @(posedge clock);
            #1;
        end
        chk("busy-start done count", 64'(dones), 64'(1));
        chk("busy-start inA", got, 64'hFFFB0000_000A0000);

        // Reset in MUL2 aborts with no write-back.
        launch(MUL, 64'h00010000_00020000, 64'h00030000_00040000, 4'd7);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("abort busy", 64'(busy), 64'(0));
        chk("abort done", 64'(done), 64'(0));
        chk("abort regwen", 64'(regwen), 64'(0));
        chk("abort inA", inA, 64'd0);
        reset = 1'b0;
        dones = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clock);
            #1;
            if (regwen === 1'b1 || done === 1'b1) dones++;
        end
        chk("abort no write-back", 64'(dones), 64'(0));

        // Accumulator must have been cleared by reset.
        v.op = MAC; v.a = 64'h00010000_00000000; v.b = 64'h00020000_00000000;
        v.dst = 4'd3; v.exp = 64'h00020000_00000000; v.ovf = 1'b0; v.wen = 1'b1; v.lat = 5;
        run_vec("mac after reset", v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
